// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INS_W  = 24;

  localparam int unsigned OPC_HI = 23;
  localparam int unsigned OPC_LO = 19;
  localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [ADDR_W-1:0] DEF_RESET_VEC = 8'h00;
  localparam logic [INS_W-1:0]  DEF_NOP_INS   = 24'h000000;
  localparam logic [OPC_W-1:0]  DEF_HALT_OPC  = 5'b11010;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INS_W-1:0] ins);
    return ins[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, its fetch address and a valid flag.
module if_id_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [INS_W-1:0] NOP_INS = DEF_NOP_INS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [INS_W-1:0]  ins_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [INS_W-1:0]  ins_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o
);

  logic [INS_W-1:0]  ins_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;

  // A bubble replaces only the instruction and valid flag; the address is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ins_q   <= NOP_INS;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else if (load_i) begin
      ins_q   <= ins_i;
      addr_q  <= addr_i;
      valid_q <= 1'b1;
    end
  end

  assign ins_o   = ins_q;
  assign addr_o  = addr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, BOOT/RUN/HALT control, IF/ID register.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [INS_W-1:0]  NOP_INS   = DEF_NOP_INS,
  parameter logic [OPC_W-1:0]  HALT_OPC  = DEF_HALT_OPC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_mux_sel,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              stall,
  input  logic [INS_W-1:0]  imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INS_W-1:0]  ins_out,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ins_valid,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q;
  logic              load, bubble;
  logic              halt_hit;

  assign halt_hit = ins_valid && (opcode_of(ins_out) == HALT_OPC);

  // Redirect outranks stall, stall outranks halt entry, so halt_hit alone
  // implies stall=0 and pc_mux_sel=0 where it is tested.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        bubble  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pc_mux_sel) begin
          pc_d   = jmp_loc;
          bubble = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_hit) begin
          bubble  = 1'b1;
          state_d = ST_HALT;
        end else begin
          load = 1'b1;
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      ST_HALT: begin
        bubble = 1'b1;
        if (pc_mux_sel) begin
          pc_d    = jmp_loc;
          state_d = ST_RUN;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  if_id_reg #(
    .NOP_INS(NOP_INS)
  ) u_if_id (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load),
    .bubble_i(bubble),
    .ins_i   (imem_data),
    .addr_i  (pc_q),
    .ins_o   (ins_out),
    .addr_o  (cur_addr),
    .valid_o (ins_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = halted_q;

endmodule
